mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 128-bit block-wide data-memory port between the instruction cache
//  (read-only) and the data cache (read/write-back). Sits between both cache FSMs and the
//  main memory model. Grants one requester at a time, round-robin, for a whole transaction.
//  Holds the returned block for the cache's CACHE_UPDATE cycle and watches for memory hangs.
// PARAMETERS
//  BADDR_W   28   block-address width; byte address bits [31:4] select the block
//  DATA_W    128  block width in bits
//  TIMEOUT   255  max cycles one grant may stay open before it is forcibly closed
// PORTS
//  clock           in   1        single system clock, posedge
//  reset           in   1        asynchronous, active-low
//  i_read          in   1        icache block-read request
//  i_address       in   BADDR_W  icache block address
//  i_busywait      out  1        icache stall
//  d_read          in   1        dcache block-read request
//  d_write         in   1        dcache block write-back request
//  d_address       in   BADDR_W  dcache block address
//  d_writedata     in   DATA_W   dcache write-back block
//  c_readdata      out  DATA_W   registered read block, shared by both caches
//  d_busywait      out  1        dcache stall
//  mem_read        out  1        memory read strobe
//  mem_write       out  1        memory write strobe
//  mem_address     out  BADDR_W  memory block address
//  mem_writedata   out  DATA_W   memory write block
//  mem_readdata    in   DATA_W   memory read block
//  mem_busywait    in   1        memory busy
//  timeout_err     out  1        sticky; a grant hit TIMEOUT
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, last_grant=D, seen_busy=0, cnt=0, c_readdata=0,
//  timeout_err=0. All mem_* outputs and both busywaits are 0 while reset is low.
//  FSM: IDLE, GNT_I, GNT_D, RELEASE.
//  - IDLE: on a request, go to GNT_I or GNT_D at the next posedge.
//      Both requesting: grant the one that is not last_grant.
//      A requester is stalled while its request is high and it is not yet granted.
//  - GNT_x: drive mem_* from the granted requester's inputs, captured at grant.
//      mem_read/mem_write are driven from the state register, so there is no comb path
//      from a requester input to the memory strobes.
//      d_read && d_write together is illegal; the write is forwarded.
//      seen_busy sets on the first posedge with mem_busywait=1.
//      done = seen_busy && !mem_busywait.
//      On done: latch c_readdata<=mem_readdata (reads only), set last_grant, go to RELEASE.
//  - RELEASE: exactly one cycle. mem_read=mem_write=0, both busywaits=0.
//      Return to IDLE, so the next request is arbitrated fresh. No back-to-back re-grant.
//  - Granted busywait = 1 until the done cycle, then 0 in the done cycle.
//      The cache samples !busywait at the following posedge.
//  - Latency, idle port: request seen at posedge N, mem strobe from N+1.
//      The cache sees busywait=0 in the memory's done cycle.
//      Total = memory latency + 1 grant cycle + 1 RELEASE cycle.
//  - Request dropped mid-grant: the memory op runs to done anyway (no abort);
//      the address/data captured at grant are held.
//  - Timeout: cnt counts cycles in GNT_x and clears in IDLE.
//      cnt==TIMEOUT forces RELEASE, sets timeout_err and c_readdata=0.
//  - Reset low mid-grant: the FSM aborts at once; the memory model must also be reset.
// STRUCTURE
//  Shared include mem_port_defs.vh:
//    state encodings IDLE=2'd0, GNT_I=1, GNT_D=2, RELEASE=3;
//    BADDR_W/DATA_W defaults; requester IDs REQ_I=0, REQ_D=1.
//  One sub-module, rr_pick2: a 2-way round-robin picker.
//    Inputs: req[1:0], last. Output: grant id, valid. Purely combinational.
//  The FSM, the capture registers and the timeout counter stay in mem_port_arbiter.
// TESTING  (memory model: busywait rises 1 cycle after strobe, 5-cycle access)
//  1. i_read only, addr 0x0000010 -> mem_read=1, mem_address=0x0000010 from next cycle.
//     c_readdata = model data; i_busywait=0 in the done cycle; then RELEASE, IDLE.
//  2. i_read and d_read in the same cycle, last_grant=D -> icache served first.
//     The dcache stays stalled and is granted only after RELEASE.
//  3. dcache write-back 0xDEADBEEF_... to block 0x5 followed by a read of block 0x9.
//     Expect mem_write, then RELEASE, then mem_read; the memory holds the written block.
//  4. Continuous requests from both caches -> grants alternate I,D,I,D over 8
//     transactions; neither is granted twice in a row.
//  5. mem_busywait held at 1 for 300 cycles -> forced RELEASE after 255 grant cycles.
//     timeout_err=1 until reset; c_readdata=0.
//  6. reset driven low at cycle 3 of GNT_D -> all outputs 0 within the same cycle, no clock
//     edge needed; after reset release, a new i_read is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the 128-bit block memory port arbiter.
// State codes and requester IDs are fixed values that other blocks may decode.
package mem_port_arbiter_pkg;

  localparam int BADDR_W     = 28;
  localparam int DATA_W      = 128;
  localparam int TIMEOUT_DEF = 255;

  typedef logic [BADDR_W-1:0] baddr_t;
  typedef logic [DATA_W-1:0]  block_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GNT_I   = 2'd1;
  localparam logic [1:0] ST_GNT_D   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  function automatic logic [1:0] gnt_state(input logic id);
    return (id == REQ_D) ? ST_GNT_D : ST_GNT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and main memory.
// A busywait of 0 at a posedge completes the requester's transaction.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic       i_read;
  baddr_t     i_address;
  logic       i_busywait;
  logic       d_read;
  logic       d_write;
  baddr_t     d_address;
  block_t     d_writedata;
  logic       d_busywait;
  block_t     c_readdata;
  logic       mem_read;
  logic       mem_write;
  baddr_t     mem_address;
  block_t     mem_writedata;
  block_t     mem_readdata;
  logic       mem_busywait;
  logic       timeout_err;
  logic [1:0] dbg_state;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_busywait, d_busywait, c_readdata, mem_read, mem_write,
           mem_address, mem_writedata, timeout_err, dbg_state
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_busywait, d_busywait, c_readdata, mem_read, mem_write,
           mem_address, mem_writedata, timeout_err, dbg_state
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
// Bit 0 is the icache, bit 1 the dcache.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_id_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |req_i;
    gnt_id_o = req_i[1];
    if (&req_i) gnt_id_o = ~last_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the shared block memory port to the icache or dcache for a whole transaction,
// holds the read block for the caches and closes grants that exceed TIMEOUT cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  block_t           rdata_q, rdata_d;
  logic             terr_q, terr_d;
  baddr_t           addr_q, addr_d;
  block_t           wdata_q, wdata_d;
  logic             wr_q, wr_d;

  logic d_req, pick_id, pick_valid, granted, done, tmo;

  assign d_req   = bus.d_read | bus.d_write;
  assign granted = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);
  assign done    = granted && seen_q && !bus.mem_busywait;
  assign tmo     = granted && !done && (cnt_q == CNT_W'(TIMEOUT));

  rr_pick2 u_pick (
    .req_i    ({d_req, bus.i_read}),
    .last_i   (last_q),
    .gnt_id_o (pick_id),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    seen_d  = seen_q;
    cnt_d   = '0;
    rdata_d = rdata_q;
    terr_d  = terr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = gnt_state(pick_id);
          addr_d  = (pick_id == REQ_D) ? bus.d_address : bus.i_address;
          wr_d    = (pick_id == REQ_D) && bus.d_write;
          wdata_d = bus.d_writedata;
          seen_d  = 1'b0;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        // cnt holds the number of grant cycles including the current one
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_busywait) seen_d = 1'b1;
        if (done) begin
          if (!wr_q) rdata_d = bus.mem_readdata;
          last_d  = (state_q == ST_GNT_D);
          state_d = ST_RELEASE;
        end else if (tmo) begin
          terr_d  = 1'b1;
          rdata_d = '0;
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= REQ_D;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Strobes come only from registers; stalls are forced low while reset is asserted.
  assign bus.mem_read      = (state_q == ST_GNT_I) || ((state_q == ST_GNT_D) && !wr_q);
  assign bus.mem_write     = (state_q == ST_GNT_D) && wr_q;
  assign bus.mem_address   = granted ? addr_q : '0;
  assign bus.mem_writedata = bus.mem_write ? wdata_q : '0;
  assign bus.i_busywait    = reset && (((state_q == ST_IDLE) && bus.i_read) ||
                                       ((state_q == ST_GNT_I) && !done) ||
                                       ((state_q == ST_GNT_D) && bus.i_read));
  assign bus.d_busywait    = reset && (((state_q == ST_IDLE) && d_req) ||
                                       ((state_q == ST_GNT_D) && !done) ||
                                       ((state_q == ST_GNT_I) && d_req));
  assign bus.c_readdata    = rdata_q;
  assign bus.timeout_err   = terr_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a bench-side memory and
// a transaction-level model of port ownership checked every cycle.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT_DEF)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- memory model: busy 1 cycle after strobe, 5-cycle access ----------------
  logic       m_busy, m_fin, m_wr, force_busy;
  logic [2:0] m_left;
  baddr_t     m_addr;
  block_t     m_wdata, m_rdata;
  block_t     wr_arr [256];
  logic [255:0] wr_valid;

  function automatic block_t pattern(input baddr_t a);
    return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
  endfunction

  function automatic block_t mem_content(input baddr_t a);
    return wr_valid[a[7:0]] ? wr_arr[a[7:0]] : pattern(a);
  endfunction

  assign bus.mem_busywait = m_busy | force_busy;
  assign bus.mem_readdata = m_rdata;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_fin <= 1'b0; m_wr <= 1'b0; m_left <= '0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; wr_valid <= '0;
    end else begin
      if (!(bus.mem_read || bus.mem_write)) m_fin <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 3'd1;
        if (m_left == 3'd1) begin
          m_busy  <= 1'b0;
          m_fin   <= 1'b1;
          m_rdata <= mem_content(m_addr);
          if (m_wr) wr_valid[m_addr[7:0]] <= 1'b1;
        end
      end else if ((bus.mem_read || bus.mem_write) && !m_fin) begin
        m_busy  <= 1'b1;
        m_left  <= 3'd5;
        m_wr    <= bus.mem_write;
        m_addr  <= bus.mem_address;
        m_wdata <= bus.mem_writedata;
      end
    end
  end

  always @(posedge clock)
    if (rst_n && m_busy && m_left == 3'd1 && m_wr) wr_arr[m_addr[7:0]] <= m_wdata;

  // ---------------- reference model: who owns the port, in cycle arithmetic ----------------
  int     cyc = 0;
  logic [1:0] mo_owner;
  logic   mo_last, mo_seen, mo_wr, mo_terr, mo_pick, tb_d_req;
  baddr_t mo_addr;
  block_t mo_wdata, mo_rdata;
  int     mo_gstart;

  always @(posedge clock) cyc <= cyc + 1;

  assign tb_d_req = bus.d_read | bus.d_write;
  assign mo_pick  = (bus.i_read && tb_d_req) ? ~mo_last : tb_d_req;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mo_owner <= ST_IDLE; mo_last <= REQ_D; mo_seen <= 1'b0; mo_wr <= 1'b0;
      mo_terr <= 1'b0; mo_addr <= '0; mo_wdata <= '0; mo_rdata <= '0; mo_gstart <= 0;
    end else begin
      case (mo_owner)
        ST_IDLE:
          if (bus.i_read || tb_d_req) begin
            mo_owner  <= mo_pick ? ST_GNT_D : ST_GNT_I;
            mo_addr   <= mo_pick ? bus.d_address : bus.i_address;
            mo_wr     <= mo_pick && bus.d_write;
            mo_wdata  <= bus.d_writedata;
            mo_seen   <= 1'b0;
            mo_gstart <= cyc;
          end
        ST_GNT_I, ST_GNT_D:
          if (mo_seen && !bus.mem_busywait) begin
            if (!mo_wr) mo_rdata <= mem_content(mo_addr);
            mo_last  <= (mo_owner == ST_GNT_D);
            mo_owner <= ST_RELEASE;
          end else if (cyc - mo_gstart == TIMEOUT_DEF) begin
            mo_owner <= ST_RELEASE;
            mo_terr  <= 1'b1;
            mo_rdata <= '0;
          end else if (bus.mem_busywait) mo_seen <= 1'b1;
        default: mo_owner <= ST_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare and grant log ----------------
  logic [0:0] glog [$];
  logic [0:0] exp_q [$];
  logic [1:0] prev_state = ST_IDLE;
  int         mw_cnt = 0;

  always @(negedge clock) begin
    logic g, dn, emr, emw, eib, edb;
    g   = (mo_owner == ST_GNT_I) || (mo_owner == ST_GNT_D);
    dn  = g && mo_seen && !bus.mem_busywait;
    emr = (mo_owner == ST_GNT_I) || ((mo_owner == ST_GNT_D) && !mo_wr);
    emw = (mo_owner == ST_GNT_D) && mo_wr;
    eib = rst_n && (((mo_owner == ST_IDLE) && bus.i_read) ||
                    ((mo_owner == ST_GNT_I) && !dn) || ((mo_owner == ST_GNT_D) && bus.i_read));
    edb = rst_n && (((mo_owner == ST_IDLE) && tb_d_req) ||
                    ((mo_owner == ST_GNT_D) && !dn) || ((mo_owner == ST_GNT_I) && tb_d_req));
    check("cyc_state",    128'(bus.dbg_state),     128'(mo_owner));
    check("cyc_mem_read", 128'(bus.mem_read),      128'(emr));
    check("cyc_mem_write",128'(bus.mem_write),     128'(emw));
    check("cyc_mem_addr", 128'(bus.mem_address),   128'(g ? mo_addr : '0));
    check("cyc_mem_wdata",bus.mem_writedata,       emw ? mo_wdata : '0);
    check("cyc_i_busy",   128'(bus.i_busywait),    128'(eib));
    check("cyc_d_busy",   128'(bus.d_busywait),    128'(edb));
    check("cyc_rdata",    bus.c_readdata,          mo_rdata);
    check("cyc_terr",     128'(bus.timeout_err),   128'(mo_terr));
    if (bus.mem_write) mw_cnt++;
    if ((bus.dbg_state == ST_GNT_I || bus.dbg_state == ST_GNT_D) && bus.dbg_state != prev_state)
      glog.push_back(bus.dbg_state == ST_GNT_D);
    prev_state = bus.dbg_state;
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic id, input logic wr, input baddr_t a, input block_t wd,
                        output int n_edges);
    bit ok;
    @(posedge clock); #2;
    if (id == REQ_I) begin
      bus.i_read = 1'b1; bus.i_address = a;
    end else begin
      bus.d_read = !wr; bus.d_write = wr; bus.d_address = a; bus.d_writedata = wd;
    end
    ok = 1'b0;
    n_edges = 0;
    for (int k = 0; k < 600 && !ok; k++) begin
      #1;
      if (bus.dbg_state == gnt_state(id) && !(id ? bus.d_busywait : bus.i_busywait)) ok = 1'b1;
      else begin @(posedge clock); #2; n_edges++; end
    end
    if (id == REQ_I) bus.i_read = 1'b0;
    else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    check("req_completes", 128'(ok), 128'(1));
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2; rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #2; rst_n = 1'b1;
  endtask

  task automatic check_glog(input string name);
    check({name, "_len"}, 128'(glog.size()), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < glog.size(); k++)
      check(name, 128'(glog[k]), 128'(exp_q[k]));
  endtask

  // ---------------- stimulus ----------------
  localparam block_t WB_DATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  initial begin
    int n;
    bus.i_read = 1'b1; bus.i_address = '0; bus.d_read = 1'b1; bus.d_write = 1'b0;
    bus.d_address = '0; bus.d_writedata = '0; force_busy = 1'b0;

    // reset state, with requests held high
    repeat (3) @(posedge clock);
    #2;
    check("rst_state",  128'(bus.dbg_state),  128'(ST_IDLE));
    check("rst_i_busy", 128'(bus.i_busywait), 128'(0));
    check("rst_d_busy", 128'(bus.d_busywait), 128'(0));
    check("rst_strobe", 128'(bus.mem_read | bus.mem_write), 128'(0));
    check("rst_rdata",  bus.c_readdata, 128'(0));
    check("rst_terr",   128'(bus.timeout_err), 128'(0));
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    @(posedge clock); #2; rst_n = 1'b1;

    // 1: single icache read of block 0x10
    @(posedge clock); #2;
    bus.i_read = 1'b1; bus.i_address = 28'h0000010;
    #1 check("t1_stall_idle", 128'(bus.i_busywait), 128'(1));
    @(posedge clock); #2;
    check("t1_mem_read", 128'(bus.mem_read), 128'(1));
    check("t1_mem_addr", 128'(bus.mem_address), 128'(28'h0000010));
    check("t1_state",    128'(bus.dbg_state), 128'(ST_GNT_I));
    n = 1;
    #1;
    while (bus.i_busywait && n < 50) begin @(posedge clock); #3; n++; end
    check("t1_latency", 128'(n), 128'(7));
    bus.i_read = 1'b0;
    @(posedge clock); #2;
    check("t1_release", 128'(bus.dbg_state), 128'(ST_RELEASE));
    check("t1_rdata",   bus.c_readdata, {28'h0000010, 4'h1, 28'h0000010, 4'h2,
                                         28'h0000010, 4'h3, 28'h0000010, 4'h4});
    @(posedge clock); #2;
    check("t1_idle", 128'(bus.dbg_state), 128'(ST_IDLE));

    // 2: simultaneous requests after reset (last = D) -> icache first
    pulse_reset();
    glog.delete(); exp_q = '{1'b0, 1'b1};
    fork
      begin int x; do_req(REQ_I, 1'b0, 28'h30, '0, x); end
      begin int y; do_req(REQ_D, 1'b0, 28'h31, '0, y); end
      begin
        repeat (2) @(posedge clock);
        #4;
        check("t2_first_i", 128'(bus.dbg_state), 128'(ST_GNT_I));
        check("t2_d_stall", 128'(bus.d_busywait), 128'(1));
      end
    join
    check_glog("t2_order");

    // 3: write-back to block 5, read block 9, read block 5 back
    mw_cnt = 0;
    do_req(REQ_D, 1'b1, 28'h5, WB_DATA, n);
    check("t3_saw_write", 128'(mw_cnt != 0), 128'(1));
    do_req(REQ_D, 1'b0, 28'h9, '0, n);
    @(posedge clock); #2;
    check("t3_rd9", bus.c_readdata, pattern(28'h9));
    do_req(REQ_D, 1'b0, 28'h5, '0, n);
    @(posedge clock); #2;
    check("t3_rd5_written", bus.c_readdata, WB_DATA);

    // 4: both caches requesting continuously -> strict alternation
    glog.delete();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fork
      for (int k = 0; k < 4; k++) begin int x; do_req(REQ_I, 1'b0, baddr_t'($urandom_range(0, 255)), '0, x); end
      for (int k = 0; k < 4; k++) begin int y; do_req(REQ_D, 1'b0, baddr_t'($urandom_range(0, 255)), '0, y); end
    join
    check_glog("t4_alt");

    // random traffic from both caches
    fork
      for (int k = 0; k < 12; k++) begin
        int x;
        repeat ($urandom_range(0, 4)) @(posedge clock);
        do_req(REQ_I, 1'b0, baddr_t'($urandom_range(0, 255)), '0, x);
      end
      for (int k = 0; k < 12; k++) begin
        int y;
        block_t wd;
        wd = {$urandom, $urandom, $urandom, $urandom};
        repeat ($urandom_range(0, 4)) @(posedge clock);
        do_req(REQ_D, 1'($urandom_range(0, 1)), baddr_t'($urandom_range(0, 255)), wd, y);
      end
    join

    // 5: memory hangs -> forced release after TIMEOUT grant cycles
    @(posedge clock); #2;
    force_busy = 1'b1;
    bus.i_read = 1'b1; bus.i_address = 28'h20;
    n = 0;
    while (bus.dbg_state != ST_GNT_I && n < 10) begin @(posedge clock); #2; n++; end
    bus.i_read = 1'b0;
    n = 0;
    while (bus.dbg_state == ST_GNT_I && n < 400) begin
      if (bus.mem_read) n++;
      @(posedge clock); #2;
    end
    check("t5_grant_cycles", 128'(n), 128'(TIMEOUT_DEF));
    check("t5_release",      128'(bus.dbg_state), 128'(ST_RELEASE));
    check("t5_terr",         128'(bus.timeout_err), 128'(1));
    check("t5_rdata_zero",   bus.c_readdata, 128'(0));
    repeat (45) @(posedge clock);
    #2; force_busy = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    check("t5_terr_sticky", 128'(bus.timeout_err), 128'(1));

    // 6: async reset during cycle 3 of a dcache grant
    bus.d_read = 1'b1; bus.d_address = 28'h3;
    n = 0;
    while (bus.dbg_state != ST_GNT_D && n < 10) begin @(posedge clock); #2; n++; end
    repeat (2) @(posedge clock);
    #3; rst_n = 1'b0;
    #1;
    check("t6_state",  128'(bus.dbg_state), 128'(ST_IDLE));
    check("t6_strobe", 128'(bus.mem_read | bus.mem_write), 128'(0));
    check("t6_addr",   128'(bus.mem_address), 128'(0));
    check("t6_d_busy", 128'(bus.d_busywait), 128'(0));
    check("t6_rdata",  bus.c_readdata, 128'(0));
    check("t6_terr",   128'(bus.timeout_err), 128'(0));
    bus.d_read = 1'b0;
    repeat (2) @(posedge clock);
    #2; rst_n = 1'b1;
    do_req(REQ_I, 1'b0, 28'h44, '0, n);
    @(posedge clock); #2;
    check("t6_after_rd", bus.c_readdata, pattern(28'h44));

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

endmodule
